// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the ray dispatcher: the 3-component position vector and
// the dispatch FSM state encoding.
package ray_dispatcher_pkg;

    localparam int POS_W_DEFAULT = 16;

    typedef struct packed {
        logic [POS_W_DEFAULT-1:0] z;
        logic [POS_W_DEFAULT-1:0] y;
        logic [POS_W_DEFAULT-1:0] x;
    } position_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } dispatch_state_t;

endpackage

// File: rtl/ray_vector_stepper.sv
// Holds the row-start and current ray directions; steps them by du per column
// and by dv per row, component-wise modulo 2^W.
module ray_vector_stepper
    import ray_dispatcher_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             col_step,
    input  logic             row_step,
    input  logic [3*W-1:0]   cornerV,
    input  logic [3*W-1:0]   du,
    input  logic [3*W-1:0]   dv,
    output logic [3*W-1:0]   rayV
);

    logic [3*W-1:0] row_v_r;
    logic [3*W-1:0] ray_v_r;
    logic [3*W-1:0] du_r;
    logic [3*W-1:0] dv_r;
    logic [3*W-1:0] row_next_s;

    function automatic logic [3*W-1:0] vec_add(input logic [3*W-1:0] a,
                                               input logic [3*W-1:0] b);
        logic [3*W-1:0] sum;
        for (int i = 0; i < 3; i++) begin
            sum[i*W +: W] = a[i*W +: W] + b[i*W +: W];
        end
        return sum;
    endfunction

    assign row_next_s = vec_add(row_v_r, dv_r);

    // Direction registers: load at frame start, then column or row steps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_v_r <= '0;
            ray_v_r <= '0;
            du_r    <= '0;
            dv_r    <= '0;
        end else if (load) begin
            row_v_r <= cornerV;
            ray_v_r <= cornerV;
            du_r    <= du;
            dv_r    <= dv;
        end else if (col_step) begin
            ray_v_r <= vec_add(ray_v_r, du_r);
        end else if (row_step) begin
            row_v_r <= row_next_s;
            ray_v_r <= row_next_s;
        end else begin
            ray_v_r <= ray_v_r;
        end
    end

    assign rayV = ray_v_r;

endmodule

// File: rtl/ray_dispatcher.sv
// Walks every pixel of a frame in raster order, launching one ray per pixel
// into a ray unit with a two-cycle minimum issue interval.
module ray_dispatcher
    import ray_dispatcher_pkg::*;
#(
    parameter int POSITION_WIDTH = 16,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int H_COUNT        = 320,
    parameter int V_COUNT        = 240
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frameStart,
    input  logic                          abort,
    input  logic [3*POSITION_WIDTH-1:0]   cameraQ,
    input  logic [3*POSITION_WIDTH-1:0]   cornerV,
    input  logic [3*POSITION_WIDTH-1:0]   du,
    input  logic [3*POSITION_WIDTH-1:0]   dv,
    input  logic [ADDRESS_WIDTH-1:0]      frameAddress,
    output logic                          start,
    input  logic                          rayBusy,
    output logic [3*POSITION_WIDTH-1:0]   rayQ,
    output logic [3*POSITION_WIDTH-1:0]   rayV,
    output logic [ADDRESS_WIDTH-1:0]      pixelAddress,
    output logic                          frameBusy,
    output logic                          frameDone
);

    localparam int X_W = (H_COUNT > 1) ? $clog2(H_COUNT) : 1;
    localparam int Y_W = (V_COUNT > 1) ? $clog2(V_COUNT) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_COUNT - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_COUNT - 1);

    dispatch_state_t               state_r;
    dispatch_state_t               state_next_s;
    logic [X_W-1:0]                x_r;
    logic [Y_W-1:0]                y_r;
    logic [ADDRESS_WIDTH-1:0]      addr_r;
    logic [3*POSITION_WIDTH-1:0]   q_r;
    logic                          start_r;
    logic                          done_r;
    logic                          start_next_s;
    logic                          done_next_s;
    logic                          load_s;
    logic                          col_step_s;
    logic                          row_step_s;
    logic                          last_x_s;
    logic                          last_y_s;

    assign last_x_s = (x_r == X_LAST);
    assign last_y_s = (y_r == Y_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = frameStart ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: state_next_s = rayBusy ? ST_ISSUE : ST_ACK;
                ST_ACK:   state_next_s = (last_x_s && last_y_s) ? ST_IDLE : ST_ISSUE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output and datapath control decode.
    always_comb begin
        start_next_s = 1'b0;
        done_next_s  = 1'b0;
        load_s       = 1'b0;
        col_step_s   = 1'b0;
        row_step_s   = 1'b0;
        if (abort) begin
            start_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE:  load_s = frameStart;
                ST_ISSUE: start_next_s = !rayBusy;
                ST_ACK: begin
                    col_step_s  = !last_x_s;
                    row_step_s  = last_x_s && !last_y_s;
                    done_next_s = last_x_s && last_y_s;
                end
                default:  load_s = 1'b0;
            endcase
        end
    end

    // Registered pulses for the ray unit and frame completion.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            start_r <= start_next_s;
            done_r  <= done_next_s;
        end
    end

    // Pixel counters, address and origin; held steady between ACK updates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_r    <= '0;
            y_r    <= '0;
            addr_r <= '0;
            q_r    <= '0;
        end else if (load_s) begin
            x_r    <= '0;
            y_r    <= '0;
            addr_r <= frameAddress;
            q_r    <= cameraQ;
        end else if (col_step_s) begin
            x_r    <= x_r + X_W'(1);
            addr_r <= addr_r + ADDRESS_WIDTH'(1);
        end else if (row_step_s) begin
            x_r    <= '0;
            y_r    <= y_r + Y_W'(1);
            addr_r <= addr_r + ADDRESS_WIDTH'(1);
        end else begin
            addr_r <= addr_r;
        end
    end

    ray_vector_stepper #(.W(POSITION_WIDTH)) u_stepper (
        .clock    (clock),
        .reset    (reset),
        .load     (load_s),
        .col_step (col_step_s),
        .row_step (row_step_s),
        .cornerV  (cornerV),
        .du       (du),
        .dv       (dv),
        .rayV     (rayV)
    );

    assign start        = start_r;
    assign frameDone    = done_r;
    assign frameBusy    = (state_r != ST_IDLE);
    assign rayQ         = q_r;
    assign pixelAddress = addr_r;

endmodule

// File: tb/tb_ray_dispatcher.sv
// Bench for ray_dispatcher on a 4x2 frame: table of frame setups checked via an
// expected-ray queue, plus abort, priority and mid-frame reset sequences.
module tb_ray_dispatcher;
    import ray_dispatcher_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int PW = 16;
    localparam int AW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            frameStart;
    logic            abort;
    logic            rayBusy;
    logic            start;
    logic            frameBusy;
    logic            frameDone;
    logic [3*PW-1:0] cameraQ, cornerV, du, dv, rayQ, rayV;
    logic [AW-1:0]   frameAddress, pixelAddress;

    always #5 clock = ~clock;

    ray_dispatcher #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .H_COUNT(H), .V_COUNT(V)) dut (
        .clock(clock), .reset(reset), .frameStart(frameStart), .abort(abort),
        .cameraQ(cameraQ), .cornerV(cornerV), .du(du), .dv(dv),
        .frameAddress(frameAddress), .start(start), .rayBusy(rayBusy),
        .rayQ(rayQ), .rayV(rayV), .pixelAddress(pixelAddress),
        .frameBusy(frameBusy), .frameDone(frameDone)
    );

    typedef struct {
        position_t   q;
        position_t   corner;
        position_t   du;
        position_t   dv;
        logic [31:0] addr;
        int          busy;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [47:0] v;
        logic [47:0] q;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[4];
    vec_t vr;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_s = -100;
    int   fs_cyc = 0;
    int   busy_k = 0;
    int   start_cnt = 0;
    int   done_cnt = 0;
    bit   first_pending = 1'b0;
    bit   prev_done = 1'b0;

    function automatic position_t mkpos(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        position_t p;
        p.x = x;
        p.y = y;
        p.z = z;
        return p;
    endfunction

    function automatic vec_t mkvec(input position_t q, input position_t c, input position_t u,
                                   input position_t w, input logic [31:0] a, input int b);
        vec_t v;
        v.q = q; v.corner = c; v.du = u; v.dv = w; v.addr = a; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // One clock: observe outputs at the falling edge, score starts, drive rayBusy.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        if (start) begin
            check("start_while_busy", {63'd0, rayBusy}, 64'd0);
            check("busy_at_start", {63'd0, frameBusy}, 64'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_start actual=1 expected=0");
            end else begin
                e = exp_q.pop_front();
                check("pixel_address", {32'd0, pixelAddress}, {32'd0, e.addr});
                check("ray_v", {16'd0, rayV}, {16'd0, e.v});
                check("ray_q", {16'd0, rayQ}, {16'd0, e.q});
            end
            if (first_pending) begin
                check("first_latency", 64'(cyc - fs_cyc), 64'd2);
                first_pending = 1'b0;
            end else begin
                check("issue_gap", 64'(cyc - last_s), 64'(busy_k + 2));
            end
            last_s = cyc;
            start_cnt++;
        end
        if (frameDone) begin
            done_cnt++;
            check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        end
        prev_done = frameDone;
        rayBusy = reset && (busy_k > 0) && (cyc > last_s) && (cyc <= last_s + busy_k);
    endtask

    task automatic set_inputs(input vec_t v);
        cameraQ      = v.q;
        cornerV      = v.corner;
        du           = v.du;
        dv           = v.dv;
        frameAddress = v.addr;
        busy_k       = v.busy;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t      e;
        position_t p;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                p.x = v.corner.x + v.du.x * 16'(x) + v.dv.x * 16'(y);
                p.y = v.corner.y + v.du.y * 16'(x) + v.dv.y * 16'(y);
                p.z = v.corner.z + v.du.z * 16'(x) + v.dv.z * 16'(y);
                e.addr = v.addr + 32'(y * H + x);
                e.v    = p;
                e.q    = v.q;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic begin_frame(input vec_t v);
        set_inputs(v);
        push_frame(v);
        start_cnt     = 0;
        done_cnt      = 0;
        first_pending = 1'b1;
        frameStart    = 1'b1;
        fs_cyc        = cyc;
        tick();
        frameStart    = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        begin_frame(v);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) tick();
        check("frame_done_seen", 64'(done_cnt), 64'd1);
        check("start_count", 64'(start_cnt), 64'(H * V));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (8) tick();
        check("idle_after_frame", {63'd0, frameBusy}, 64'd0);
        check("done_once", 64'(done_cnt), 64'd1);
        exp_q.delete();
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 500 && start_cnt < n; i++) tick();
        check("wait_starts", 64'(start_cnt), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, {63'd0, start}, 64'd0);
        check({tag, "_frameBusy"}, {63'd0, frameBusy}, 64'd0);
        check({tag, "_frameDone"}, {63'd0, frameDone}, 64'd0);
        check({tag, "_rayQ"}, {16'd0, rayQ}, 64'd0);
        check({tag, "_rayV"}, {16'd0, rayV}, 64'd0);
        check({tag, "_pixelAddress"}, {32'd0, pixelAddress}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; frameStart = 1'b0; abort = 1'b0; rayBusy = 1'b0;
        cameraQ = '0; cornerV = '0; du = '0; dv = '0; frameAddress = '0;

        tbl[0] = mkvec(mkpos(16'h0010, 16'h0020, 16'h0030), mkpos(16'd0, 16'd0, 16'd100),
                       mkpos(16'd1, 16'd0, 16'd0), mkpos(16'd0, 16'd1, 16'd0), 32'h0000_1000, 0);
        tbl[1] = mkvec(mkpos(16'hAAAA, 16'h5555, 16'h1234), mkpos(16'd1, 16'd2, 16'd3),
                       mkpos(16'hFFFF, 16'd0, 16'd0), mkpos(16'd0, 16'd0, 16'd1), 32'h0000_2000, 0);
        tbl[2] = mkvec(mkpos(16'd1, 16'd2, 16'd3), mkpos(16'd0, 16'd0, 16'd100),
                       mkpos(16'd1, 16'd0, 16'd0), mkpos(16'd0, 16'd1, 16'd0), 32'h0000_1000, 5);
        tbl[3] = mkvec(mkpos(16'hFFFF, 16'd0, 16'h8001), mkpos(16'h8000, 16'h7FFF, 16'hFFFF),
                       mkpos(16'h1234, 16'hFFFE, 16'd1), mkpos(16'h8000, 16'd3, 16'hFFFF),
                       32'hFFFF_FFFE, 2);

        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        // Abort from ISSUE right after the third launch.
        begin_frame(tbl[1]);
        wait_starts(3);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_frameBusy", {63'd0, frameBusy}, 64'd0);
        repeat (10) tick();
        check("abort_no_start", 64'(start_cnt), 64'd3);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        exp_q.delete();

        // Abort wins over a simultaneous frameStart.
        frameStart = 1'b1;
        abort      = 1'b1;
        tick();
        frameStart = 1'b0;
        abort      = 1'b0;
        check("abort_priority", {63'd0, frameBusy}, 64'd0);
        tick();
        run_frame(tbl[1]);

        // frameStart ignored mid-frame, then asynchronous reset with start high.
        vr      = tbl[0];
        vr.addr = 32'h0000_3000;
        begin_frame(vr);
        wait_starts(2);
        frameAddress = 32'h0000_5000;
        cornerV      = mkpos(16'd7, 16'd7, 16'd7);
        du           = mkpos(16'd5, 16'd5, 16'd5);
        frameStart   = 1'b1;
        tick();
        tick();
        frameStart   = 1'b0;
        wait_starts(5);
        #1 reset = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        repeat (5) tick();
        check("reset_no_start", 64'(start_cnt), 64'd5);
        reset = 1'b1;
        tick();
        run_frame(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ray_dispatcher.md
RAY_DISPATCHER -- requirements
Module: ray_dispatcher

Interface
REQ-001 SHALL have parameter POSITION_WIDTH, default 16, the fixed-point vector component width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, the pixel address width.
REQ-003 SHALL have parameter H_COUNT, default 320, pixels per row.
REQ-004 SHALL have parameter V_COUNT, default 240, rows per frame.
REQ-005 SHALL have port clock, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port frameStart, input, 1 bit: begins a frame when idle.
REQ-008 SHALL have port abort, input, 1 bit: cancels the frame in progress.
REQ-009 SHALL have port cameraQ, input, 3 x POSITION_WIDTH: ray origin.
REQ-010 SHALL have port cornerV, input, 3 x POSITION_WIDTH: direction for pixel (0,0).
REQ-011 SHALL have ports du and dv, input, 3 x POSITION_WIDTH each: per-column and per-row direction steps.
REQ-012 SHALL have port frameAddress, input, ADDRESS_WIDTH: address of pixel (0,0).
REQ-013 SHALL have port start, output, 1 bit: one-cycle launch pulse to the ray unit.
REQ-014 SHALL have port rayBusy, input, 1 bit: the ray unit's busy signal.
REQ-015 SHALL have ports rayQ and rayV, output, 3 x POSITION_WIDTH each, and pixelAddress, output, ADDRESS_WIDTH: the current ray.
REQ-016 SHALL have ports frameBusy, output, 1 bit, and frameDone, output, 1 bit: frameDone is a one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, ISSUE and ACK.
REQ-018 In IDLE with frameStart=1, SHALL latch cameraQ, du, dv and frameAddress; set rayV=rowV=cornerV, x=0, y=0, pixelAddress=frameAddress; and enter ISSUE.
REQ-019 In IDLE, frameStart=0 SHALL keep the block in IDLE; frameStart is ignored in all other states.
REQ-020 In ISSUE, if rayBusy=0, SHALL register start=1 for exactly one cycle and enter ACK; if rayBusy=1, SHALL stay in ISSUE.
REQ-021 ACK SHALL last one cycle with rayBusy ignored, which covers the ray unit's one-cycle busy latency.
REQ-022 In ACK, if x<H_COUNT-1, SHALL set x+=1, rayV+=du, pixelAddress+=1 and return to ISSUE.
REQ-023 In ACK with x=H_COUNT-1 and y<V_COUNT-1, SHALL set x=0, y+=1, rowV+=dv, rayV=rowV+dv, pixelAddress+=1 and return to ISSUE.
REQ-024 In ACK at the last pixel, SHALL pulse frameDone for one cycle and enter IDLE.
REQ-025 rayQ, rayV and pixelAddress SHALL be stable from the start cycle until the following ACK update.
REQ-026 Vector additions SHALL be per component, modulo 2^POSITION_WIDTH, with no saturation.
REQ-027 pixelAddress SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-028 frameBusy SHALL equal 1 whenever the state is not IDLE.
REQ-029 abort=1 in any state SHALL force IDLE on the next edge with no frameDone, and SHALL suppress start in that same cycle; abort has priority over frameStart.
REQ-030 Latency SHALL be: frameStart at cycle N gives start at cycle N+2 when rayBusy=0; minimum issue interval is 2 cycles per pixel.

Reset
REQ-031 While reset=0, SHALL hold state=IDLE and start=0, frameBusy=0, frameDone=0, rayQ=0, rayV=0, pixelAddress=0, x=0, y=0.
REQ-032 Reset asserted mid-frame SHALL take effect immediately, asynchronously, with no further start pulses.

Structure
REQ-033 A shared package SHALL hold the position_t vector typedef and the dispatch-state enum.
REQ-034 H_COUNT and V_COUNT SHALL stay module parameters; counter widths SHALL be derived with $clog2.
REQ-035 A sub-module ray_vector_stepper SHALL hold rowV and rayV and perform the column and row steps.

Verification
REQ-036 H_COUNT=4, V_COUNT=2, rayBusy tied 0, frameAddress=0x1000: bench SHALL see exactly 8 start pulses, pixelAddress 0x1000..0x1007 in order, and one frameDone.
REQ-037 cornerV=(0,0,100), du=(1,0,0), dv=(0,1,0): the 6th start (x=1, y=1) SHALL carry rayV=(1,1,100).
REQ-038 Bench model holding rayBusy=1 for 5 cycles after each start: bench SHALL see no start while busy, and each next start one cycle after busy falls.
REQ-039 du=(0xFFFF,0,0) from cornerV=(0x0001,...): 2nd pixel rayV.x SHALL equal 0x0000, confirming wrap.
REQ-040 abort asserted after the 3rd start: bench SHALL see frameBusy=0 next cycle, no further start, and no frameDone; a new frameStart SHALL then restart at pixel (0,0).
REQ-041 reset pulsed low mid-frame: bench SHALL see all outputs zero immediately; frameStart asserted during an active frame SHALL be ignored.
